// File: rtl/inference_sequencer.sv
// inference_sequencer
//   Control sequencer for a single-hidden-layer inference engine. It rewrites
//   the activation table on request, then for each inference clears the
//   accumulate datapath, steps through every hidden neuron index, waits for
//   the pipeline to drain, strobes the output-layer capture, and scans the
//   ten class scores for the argmax.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle request to run one inference (IDLE only)
//   load_start          one-cycle request to rewrite the activation table (IDLE only)
//   lut_valid, lut_data activation-table word stream (accepted during LOAD)
//   results             ten signed 16-bit class scores, score k at [16k+15:16k]
//   core_reset          reset to the accumulate datapath
//   enable_layer3       capture strobe for the output registers
//   we, wdata, waddr    activation-table write port
//   hidden_idx          hidden neuron index currently presented
//   busy                high whenever the sequencer is not idle
//   done                one-cycle pulse when class_id is valid
//   class_id            argmax of results, held until the next done
module inference_sequencer #(
  parameter int N_HIDDEN     = 98,
  parameter int STEP_CYCLES  = 4,
  parameter int CLR_CYCLES   = 12,
  parameter int DRAIN_CYCLES = 3,
  parameter int LUT_DEPTH    = 65536
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         load_start,
  input  logic         lut_valid,
  input  logic [15:0]  lut_data,
  input  logic [159:0] results,
  output logic         core_reset,
  output logic         enable_layer3,
  output logic         we,
  output logic [15:0]  wdata,
  output logic [15:0]  waddr,
  output logic [15:0]  hidden_idx,
  output logic         busy,
  output logic         done,
  output logic [3:0]   class_id
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLR, S_STEP, S_DRAIN, S_CAPTURE, S_ARGMAX, S_DONE
  } state_t;

  localparam logic [15:0] LAST_ADDR  = 16'(LUT_DEPTH - 1);
  localparam logic [15:0] CLR_LAST   = 16'(CLR_CYCLES - 1);
  localparam logic [15:0] STEP_LAST  = 16'(STEP_CYCLES - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [15:0] HIDX_LAST  = 16'(N_HIDDEN - 1);
  localparam logic [15:0] ARG_LAST   = 16'd9;

  state_t             state_q, state_d;
  logic [15:0]        waddr_q, waddr_d;
  logic [15:0]        cyc_q, cyc_d;
  logic [15:0]        hidx_q, hidx_d;
  logic signed [15:0] max_val_q, max_val_d;
  logic [3:0]         max_idx_q, max_idx_d;
  logic [3:0]         class_q, class_d;
  // Holds core_reset high for the cycle after a reset edge, then releases it.
  logic               rst_seen_q;

  // Unpack the score bus so the argmax scan can select by cycle count.
  logic signed [15:0] score_arr [10];
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_score
      assign score_arr[gi] = results[16*gi +: 16];
    end
  endgenerate

  logic signed [15:0] score;
  logic               take;
  logic [3:0]         new_idx;

  always_comb begin
    score = '0;
    for (int k = 0; k < 10; k++) begin
      if (cyc_q == 16'(k)) score = score_arr[k];
    end
    // First score seeds the running max; later ones replace it only when
    // strictly greater, so ties resolve to the lowest index.
    take    = (cyc_q == 16'd0) || (score > max_val_q);
    new_idx = take ? cyc_q[3:0] : max_idx_q;
  end

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    cyc_d     = cyc_q;
    hidx_d    = hidx_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    class_d   = class_q;
    case (state_q)
      S_IDLE: begin
        cyc_d  = '0;
        hidx_d = '0;
        if (load_start) begin
          waddr_d = '0;
          state_d = S_LOAD;
        end else if (start) begin
          state_d = S_CLR;
        end
      end
      S_LOAD: begin
        if (lut_valid) begin
          if (waddr_q == LAST_ADDR) begin
            waddr_d = '0;
            state_d = S_IDLE;
          end else begin
            waddr_d = waddr_q + 16'd1;
          end
        end
      end
      S_CLR: begin
        if (cyc_q == CLR_LAST) begin
          cyc_d   = '0;
          hidx_d  = '0;
          state_d = S_STEP;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      S_STEP: begin
        if (cyc_q == STEP_LAST) begin
          cyc_d = '0;
          if (hidx_q == HIDX_LAST) state_d = S_DRAIN;
          else                     hidx_d  = hidx_q + 16'd1;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      S_DRAIN: begin
        if (cyc_q == DRAIN_LAST) begin
          cyc_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      S_CAPTURE: begin
        cyc_d   = '0;
        state_d = S_ARGMAX;
      end
      S_ARGMAX: begin
        if (take) begin
          max_val_d = score;
          max_idx_d = cyc_q[3:0];
        end
        if (cyc_q == ARG_LAST) begin
          class_d = new_idx;
          cyc_d   = '0;
          state_d = S_DONE;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      waddr_q    <= '0;
      cyc_q      <= '0;
      hidx_q     <= '0;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      class_q    <= '0;
      rst_seen_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      cyc_q      <= cyc_d;
      hidx_q     <= hidx_d;
      max_val_q  <= max_val_d;
      max_idx_q  <= max_idx_d;
      class_q    <= class_d;
      rst_seen_q <= 1'b0;
    end
  end

  always_comb begin
    core_reset    = rst_seen_q || (state_q == S_CLR);
    enable_layer3 = (state_q == S_CAPTURE);
    we            = (state_q == S_LOAD) && lut_valid;
    wdata         = (state_q == S_LOAD) ? lut_data : 16'd0;
    waddr         = (state_q == S_LOAD) ? waddr_q : 16'd0;
    hidden_idx    = ((state_q == S_STEP) || (state_q == S_DRAIN)) ? hidx_q : 16'd0;
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    class_id      = class_q;
  end

endmodule
